// File: rtl/tile_matmul_ctrl_pkg.sv
// Shared definitions for the tiled matrix-multiply controller.
//   - state_e      : controller FSM states
//   - TILE_WORDS   : 32-bit words per 16x16 byte tile
//   - COMPUTE_CYCLES / DRAIN_BEATS : core phase lengths
//   - add16x2      : lane-wise modulo-2^16 add of two packed result pairs
package tile_matmul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_e;

  localparam int unsigned TILE_WORDS     = 64;
  localparam int unsigned COMPUTE_CYCLES = 4096;
  localparam int unsigned DRAIN_BEATS    = 128;

  // Phase counter must reach COMPUTE_CYCLES itself (one extra slot overlaps
  // the last load beat), so 13 bits.
  localparam int unsigned CNT_W = 13;

  // Two independent 16-bit lanes; carries never cross from [15:0] into [31:16].
  function automatic logic [31:0] add16x2(input logic [31:0] a, input logic [31:0] b);
    add16x2 = {a[31:16] + b[31:16], a[15:0] + b[15:0]};
  endfunction

endpackage

// File: rtl/tile_matmul_ctrl_addr_gen.sv
// tile_addr_gen: combinational word-address generator for one tile step.
// Ports:
//   bi_i, bj_i, bk_i : tile indices (row of C, column of C, reduction)
//   r_i, w_i         : row inside a 16-row tile, word inside a 4-word row
//   p_i              : drain beat 0..127 (8 result words per row)
//   tiles_i          : tiles per matrix edge
//   a/b/c_base_i     : word base addresses
//   a/b/c_addr_o     : source A, source B and result C word addresses
// All arithmetic wraps at 12 bits like the address bus.
module tile_addr_gen (
  input  logic [2:0]  bi_i,
  input  logic [2:0]  bj_i,
  input  logic [2:0]  bk_i,
  input  logic [3:0]  r_i,
  input  logic [1:0]  w_i,
  input  logic [6:0]  p_i,
  input  logic [2:0]  tiles_i,
  input  logic [11:0] a_base_i,
  input  logic [11:0] b_base_i,
  input  logic [11:0] c_base_i,
  output logic [11:0] a_addr_o,
  output logic [11:0] b_addr_o,
  output logic [11:0] c_addr_o
);

  logic [11:0] a_row_s;
  logic [11:0] b_row_s;
  logic [11:0] c_row_s;
  logic [11:0] tiles_s;

  // Matrix row numbers and the A/B (4 words per tile row) and C (8 words per
  // tile row) addresses.
  always_comb begin
    tiles_s  = {9'd0, tiles_i};
    a_row_s  = {5'd0, bi_i, 4'b0000} + {8'd0, r_i};
    b_row_s  = {5'd0, bk_i, 4'b0000} + {8'd0, r_i};
    c_row_s  = {5'd0, bi_i, 4'b0000} + {8'd0, p_i[6:3]};
    a_addr_o = a_base_i + ((a_row_s * tiles_s) << 2) + {7'd0, bk_i, 2'b00} + {10'd0, w_i};
    b_addr_o = b_base_i + ((b_row_s * tiles_s) << 2) + {7'd0, bj_i, 2'b00} + {10'd0, w_i};
    c_addr_o = c_base_i + ((c_row_s * tiles_s) << 3) + {6'd0, bj_i, 3'b000} + {9'd0, p_i[2:0]};
  end

endmodule

// File: rtl/tile_matmul_ctrl.sv
// tile_matmul_ctrl: sequences a 16x16 MAC core over an N x N (N = 16*tiles)
// row-major matrix product C = A*B, tile loop bi (outer), bj, bk (inner).
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, cfg_*               : go pulse, tiles per edge, A/B/C word bases
//   busy, done                 : run in progress, one-cycle completion pulse
//   src_rd_en/src_addr/src_rdata : A/B source memory, 1-cycle read latency
//   dst_rd_en/dst_we/dst_addr/dst_wdata/dst_rdata : C memory (read-modify-write)
//   core_reset_n/core_valid/core_data/core_result0/1 : MAC core stream
// All control and address outputs are registered and aligned with state_q;
// core_data and dst_wdata are gated pass-throughs of 1-cycle-latency data.
module tile_matmul_ctrl
  import tile_matmul_ctrl_pkg::*;
#(
  parameter int unsigned IN_DATA_WITDH = 8,
  parameter int unsigned BLOCK_SIZE    = 16,
  parameter int unsigned MAX_TILES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  cfg_tiles,
  input  logic [11:0] cfg_a_base,
  input  logic [11:0] cfg_b_base,
  input  logic [11:0] cfg_c_base,
  output logic        busy,
  output logic        done,
  output logic        src_rd_en,
  output logic [11:0] src_addr,
  input  logic [31:0] src_rdata,
  output logic        dst_rd_en,
  output logic        dst_we,
  output logic [11:0] dst_addr,
  output logic [31:0] dst_wdata,
  input  logic [31:0] dst_rdata,
  output logic        core_reset_n,
  output logic        core_valid,
  output logic [31:0] core_data,
  input  logic [15:0] core_result0,
  input  logic [15:0] core_result1
);

  // Words in one tile (TILE_WORDS at the default parameters).
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(BLOCK_SIZE * BLOCK_SIZE * IN_DATA_WITDH / 32 - 1);
  // COMPUTE runs one slot longer: its first slot carries the last load beat.
  localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES);
  // DRAIN alternates read/core beat (even cnt) and write-back (odd cnt).
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(2 * DRAIN_BEATS - 1);
  localparam logic [2:0]       MAX_T        = 3'(MAX_TILES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bi_q, bi_d, bj_q, bj_d, bk_q, bk_d;
  logic [2:0]        tiles_q, tiles_d;
  logic [11:0]       a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [2:0]        last_idx_s;

  logic              busy_q, busy_d, done_q, done_d;
  logic              src_rd_en_q, src_rd_en_d;
  logic [11:0]       src_addr_q, src_addr_d;
  logic              dst_rd_en_q, dst_rd_en_d, dst_we_q, dst_we_d;
  logic [11:0]       dst_addr_q, dst_addr_d;
  logic              core_valid_q, core_valid_d;
  logic              ld_valid_q, ld_valid_d;
  logic              core_reset_n_q;

  logic [11:0]       a_addr_s, b_addr_s, c_addr_s;

  // Addresses are generated from next-state values so the registered
  // outputs line up with the state they belong to.
  tile_addr_gen u_addr_gen (
    .bi_i     (bi_d),
    .bj_i     (bj_d),
    .bk_i     (bk_d),
    .r_i      (cnt_d[5:2]),
    .w_i      (cnt_d[1:0]),
    .p_i      (cnt_d[7:1]),
    .tiles_i  (tiles_d),
    .a_base_i (a_base_d),
    .b_base_i (b_base_d),
    .c_base_i (c_base_d),
    .a_addr_o (a_addr_s),
    .b_addr_o (b_addr_s),
    .c_addr_o (c_addr_s)
  );

  assign last_idx_s = tiles_q - 3'd1;

  // Next-state, counters, tile indices and next output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bi_d     = bi_q;
    bj_d     = bj_q;
    bk_d     = bk_q;
    tiles_d  = tiles_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tiles_d  = cfg_tiles;
          a_base_d = cfg_a_base;
          b_base_d = cfg_b_base;
          c_base_d = cfg_c_base;
          bi_d     = 3'd0;
          bj_d     = 3'd0;
          bk_d     = 3'd0;
          cnt_d    = '0;
          if ((cfg_tiles == 3'd0) || (cfg_tiles > MAX_T)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD_A;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = LOAD_B;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD_B: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMPUTE: begin
        if (cnt_q == COMPUTE_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (bk_q != last_idx_s) begin
          bk_d    = bk_q + 3'd1;
          state_d = LOAD_A;
        end else begin
          bk_d = 3'd0;
          if (bj_q != last_idx_s) begin
            bj_d    = bj_q + 3'd1;
            state_d = LOAD_A;
          end else begin
            bj_d = 3'd0;
            if (bi_q != last_idx_s) begin
              bi_d    = bi_q + 3'd1;
              state_d = LOAD_A;
            end else begin
              bi_d    = 3'd0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    src_rd_en_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    if (state_d == LOAD_A) begin
      src_addr_d = a_addr_s;
    end else if (state_d == LOAD_B) begin
      src_addr_d = b_addr_s;
    end else begin
      src_addr_d = 12'd0;
    end

    // Load beats follow each read by one cycle; compute beats start in slot 1.
    ld_valid_d   = src_rd_en_q;
    core_valid_d = src_rd_en_q
                 || ((state_d == COMPUTE) && (cnt_d != '0))
                 || ((state_d == DRAIN) && !cnt_d[0]);

    dst_rd_en_d = (state_d == DRAIN) && !cnt_d[0];
    dst_we_d    = (state_d == DRAIN) && cnt_d[0];
    if (state_d == DRAIN) begin
      dst_addr_d = c_addr_s;
    end else begin
      dst_addr_d = 12'd0;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // FSM state, phase counter, tile indices and latched configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bi_q     <= 3'd0;
      bj_q     <= 3'd0;
      bk_q     <= 3'd0;
      tiles_q  <= 3'd0;
      a_base_q <= 12'd0;
      b_base_q <= 12'd0;
      c_base_q <= 12'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bi_q     <= bi_d;
      bj_q     <= bj_d;
      bk_q     <= bk_d;
      tiles_q  <= tiles_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
    end
  end

  // Registered control/address outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      src_rd_en_q  <= 1'b0;
      src_addr_q   <= 12'd0;
      dst_rd_en_q  <= 1'b0;
      dst_we_q     <= 1'b0;
      dst_addr_q   <= 12'd0;
      core_valid_q <= 1'b0;
      ld_valid_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      src_rd_en_q  <= src_rd_en_d;
      src_addr_q   <= src_addr_d;
      dst_rd_en_q  <= dst_rd_en_d;
      dst_we_q     <= dst_we_d;
      dst_addr_q   <= dst_addr_d;
      core_valid_q <= core_valid_d;
      ld_valid_q   <= ld_valid_d;
    end
  end

  // Core reset: the register delay keeps it low one cycle past any reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_reset_n_q <= 1'b0;
    end else begin
      core_reset_n_q <= 1'b1;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign src_rd_en    = src_rd_en_q;
  assign src_addr     = src_addr_q;
  assign dst_rd_en    = dst_rd_en_q;
  assign dst_we       = dst_we_q;
  assign dst_addr     = dst_addr_q;
  assign core_valid   = core_valid_q;
  assign core_reset_n = core_reset_n_q;
  assign core_data    = ld_valid_q ? src_rdata : 32'd0;
  // First reduction pass overwrites C; later passes accumulate per 16-bit lane.
  assign dst_wdata    = !dst_we_q ? 32'd0 :
                        (bk_q == 3'd0) ? {core_result1, core_result0} :
                        add16x2(dst_rdata, {core_result1, core_result0});

endmodule

// File: doc/tile_matmul_ctrl.md
TILE_MATMUL_CTRL -- requirements
Module: tile_matmul_ctrl

Interface
REQ-001 SHALL have parameter IN_DATA_WITDH, default 8, meaning the element width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 16, meaning the core tile edge n (n x n tile).
REQ-003 SHALL have parameter MAX_TILES, default 4, meaning the maximum tiles per matrix edge (N = tiles*16, N max 64).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start, cfg_tiles[2:0], cfg_a_base[11:0], cfg_b_base[11:0], cfg_c_base[11:0], all inputs: go pulse, tiles per edge (1..MAX_TILES), and word base addresses.
REQ-007 SHALL have outputs busy (1) and done (1-cycle pulse).
REQ-008 SHALL have source read port src_rd_en, src_addr[11:0] (outputs) and src_rdata[31:0] (input) with 1-cycle read latency, holding 4 bytes per word, lowest byte at the lowest column.
REQ-009 SHALL have result port dst_rd_en, dst_we, dst_addr[11:0], dst_wdata[31:0] (outputs) and dst_rdata[31:0] (input) with 1-cycle read latency, holding two 16-bit results per word, lower column in [15:0].
REQ-010 SHALL have core port core_reset_n, core_valid, core_data[31:0] (outputs) and core_result0/1[15:0] (inputs).

Function
REQ-011 SHALL compute C = A*B for row-major N x N matrices by iterating tile indices bi (outer), bj, bk (inner) over 0..cfg_tiles-1.
REQ-012 SHALL use FSM states IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, NEXT, DONE.
REQ-013 IDLE: start=1 SHALL latch all cfg_* inputs, clear tile indices, set busy and enter LOAD_A; start while busy SHALL be ignored.
REQ-014 cfg_tiles=0 or >MAX_TILES at start SHALL go straight to DONE with no memory or core traffic.
REQ-015 LOAD_A SHALL issue 64 reads: tile row r 0..15, word w 0..3, addr = a_base + (bi*16+r)*tiles*4 + bk*4 + w.
REQ-016 LOAD_B SHALL issue 64 reads with the same formula using b_base, row bk*16+r and word offset bj*4+w.
REQ-017 core_valid SHALL be src_rd_en delayed by one cycle and core_data SHALL equal src_rdata, giving a gapless 128-beat load with LOAD_B starting the cycle after the last LOAD_A read.
REQ-018 COMPUTE SHALL hold core_valid=1 for exactly 4096 consecutive cycles (16*16*16 MACs), with core_data don't-care.
REQ-019 DRAIN SHALL drive core_valid=1 for exactly 128 beats p=0..127.
REQ-020 Each DRAIN beat p SHALL also assert dst_rd_en with addr = c_base + (bi*16 + p/8)*tiles*8 + bj*8 + (p mod 8).
REQ-021 One cycle after beat p, the block SHALL write to the same address: {core_result1, core_result0} when bk=0, else each 16-bit half added to the matching dst_rdata half, modulo 2^16.
REQ-022 DRAIN capture SHALL be counted by the controller and SHALL NOT use the core's o_valid, which is deasserted on the final pair.
REQ-023 NEXT SHALL advance bk, then bj, then bi, each wrapping to 0; it returns to LOAD_A unless all three wrap, in which case it enters DONE.
REQ-024 DONE SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-025 Total writes per run SHALL be tiles^3*128, and src/dst reads SHALL never be issued outside LOAD_A/LOAD_B/DRAIN.

Reset
REQ-026 While reset=1, the FSM SHALL enter IDLE and all counters SHALL clear.
REQ-027 While reset=1, busy, done, src_rd_en, dst_rd_en, dst_we and core_valid SHALL be 0, and all address and data outputs SHALL be 0.
REQ-028 core_reset_n SHALL be low during reset and for one cycle after any mid-run reset, so the core's A/B/C state and indices are re-initialised.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, TILE_WORDS=64, COMPUTE_CYCLES=4096 and DRAIN_BEATS=128.
REQ-030 A single sub-module, tile_addr_gen, SHALL compute the src/dst addresses from (bi,bj,bk,r,w,p,tiles,bases).
REQ-031 The core SHALL be instantiated outside this block.

Verification
REQ-032 tiles=1, A=identity, B[r][c]=r+c -> 128 writes; C word 0 = 0x0001_0000 and done after the last write.
REQ-033 tiles=2, A=B=all 2 -> 1024 writes; every 16-bit result = 128, and the bk=1 pass writes 64+64.
REQ-034 tiles=1, A=B=all 0xFF -> each result = 16*65025 mod 65536 = 57360 (0xE010), checking wrap.
REQ-035 Reset asserted mid-COMPUTE of run 1, then a new start -> run 2 completes with correct C, and core_reset_n pulses low.
REQ-036 Start pulsed while busy, and cfg_tiles=0 -> the first is ignored; the second gives done in 2 cycles with zero memory strobes.
